m_div_seq: RTL

Parametrised sequential radix-2 restoring divider for the M-extension unit, the next generation of the fixed 32-bit remainder/divisor/quotient register datapath. It owns its own FSM, start/done handshake, RISC-V signed and unsigned DIV/REM semantics, and a configurable number of quotient bits per cycle. It sits beside the multiplier inside the M unit and is driven by the M-unit controller.

---
 rtl/m_div_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/m_div_seq.sv
// m_div_seq: radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics and start/done handshake
module m_div_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_n;
    logic [XLEN-1:0] r, r_n, z, z_n, res_n, rt, zt, a_abs, b_abs;
    logic [2*XLEN-2:0] d, d_n, dt;
    logic [2*XLEN-1:0] diff;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] op_q, op_n;
    logic neg_q, neg_r, nq_n, nr_n, sgn, div0, ovf;
    assign sgn   = ~op[0];
    assign a_abs = sgn && rs1[XLEN-1] ? -rs1 : rs1;
    assign b_abs = sgn && rs2[XLEN-1] ? -rs2 : rs2;
    assign div0  = rs2 == '0;
    assign ovf   = sgn && rs1 == {1'b1, {(XLEN-1){1'b0}}} && &rs2;
    assign ready = state == IDLE;
    assign done  = state == DONE;
    always_comb begin
        rt   = r;
        dt   = d;
        zt   = z;
        diff = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            diff = {{XLEN{1'b0}}, rt} - {1'b0, dt};
            rt   = diff[2*XLEN-1] ? rt : diff[XLEN-1:0];
            zt   = {zt[XLEN-2:0], ~diff[2*XLEN-1]};
            dt   = dt >> 1;
        end
    end
    always_comb begin
        state_n = state;
        r_n     = r;
        d_n     = d;
        z_n     = z;
        cnt_n   = cnt;
        op_n    = op_q;
        nq_n    = neg_q;
        nr_n    = neg_r;
        res_n   = result;
        if (flush)
            state_n = IDLE;
        else
            case (state)
                IDLE: if (start) begin
                    if (div0 || ovf) begin
                        state_n = DONE;
                        res_n   = div0 ? (op[1] ? rs1 : '1) : (op[1] ? '0 : rs1);
                    end else begin
                        state_n = CALC;
                        r_n     = a_abs;
                        d_n     = {b_abs, {(XLEN-1){1'b0}}};
                        z_n     = '0;
                        cnt_n   = CNT_INIT;
                        op_n    = op;
                        nq_n    = sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        nr_n    = sgn & rs1[XLEN-1];
                    end
                end
                CALC: begin
                    r_n     = rt;
                    d_n     = dt;
                    z_n     = zt;
                    cnt_n   = cnt - 1'b1;
                    state_n = cnt == '0 ? FIX : CALC;
                end
                FIX: begin
                    res_n   = op_q[1] ? (neg_r ? -r : r) : (neg_q ? -z : z);
                    state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            r      <= '0;
            d      <= '0;
            z      <= '0;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            r      <= r_n;
            d      <= d_n;
            z      <= z_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            neg_q  <= nq_n;
            neg_r  <= nr_n;
            result <= res_n;
        end
    end
endmodule
